// File: rtl/sprite_plot_scheduler_pkg.sv
// rtl/sprite_plot_scheduler_pkg.sv - shared constants, state encoding and screen helper
// Screen geometry, phase encodings and FSM state type for the sprite plot scheduler.
package sprite_plot_scheduler_pkg;

   localparam logic [7:0] SCREEN_W    = 8'd160;
   localparam logic [6:0] SCREEN_H    = 7'd120;
   localparam logic       PHASE_ERASE = 1'b0;
   localparam logic       PHASE_DRAW  = 1'b1;

   // Wide enough for up to 8 requesters.
   localparam int IDX_W = 3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_E_START  = 3'd1,
      S_E_STREAM = 3'd2,
      S_D_START  = 3'd3,
      S_D_STREAM = 3'd4,
      S_COMMIT   = 3'd5
   } state_t;

   function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
      return (x < SCREEN_W) && (y < SCREEN_H);
   endfunction

endpackage

// File: rtl/sprite_plot_scheduler_next_active_idx.sv
// rtl/sprite_plot_scheduler_next_active_idx.sv - combinational priority finder over a sprite mask
// Ports:
//   mask     in  N_REQ  candidate sprites
//   idx      in  IDX_W  current sprite index
//   wrap     in  1      1: lowest set bit of mask; 0: lowest set bit strictly above idx
//   next_idx out IDX_W  selected index (0 when nothing found)
//   found    out 1      a candidate exists
module next_active_idx
   import sprite_plot_scheduler_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] idx,
   input  logic             wrap,
   output logic [IDX_W-1:0] next_idx,
   output logic             found
);

   // Scan from the top down so the lowest qualifying bit is the last writer.
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (mask[i] && (wrap || (IDX_W'(i) > idx))) begin
            next_idx = IDX_W'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// rtl/sprite_plot_scheduler.sv - per-frame erase/draw sequencer and arbiter for the VGA plot port
// Ports:
//   CLOCK_50, resetn (async, active-low)
//   frame_tick, active[N_REQ]            pass request and sprite enable mask
//   start[N_REQ], phase, commit[N_REQ]   per-sprite turn control
//   pix_valid/pix_last[N_REQ], pix_x/pix_y/pix_colour (flattened per sprite)
//   vga_x, vga_y, vga_colour, vga_plot   registered plot port
//   busy, overrun, timeout_err           status
module sprite_plot_scheduler
   import sprite_plot_scheduler_pkg::*;
#(
   parameter int         N_REQ     = 4,
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         TIMEOUT   = 64
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic [N_REQ-1:0]   active,
   output logic [N_REQ-1:0]   start,
   output logic               phase,
   output logic [N_REQ-1:0]   commit,
   input  logic [N_REQ-1:0]   pix_valid,
   input  logic [N_REQ-1:0]   pix_last,
   input  logic [8*N_REQ-1:0] pix_x,
   input  logic [7*N_REQ-1:0] pix_y,
   input  logic [3*N_REQ-1:0] pix_colour,
   output logic [7:0]         vga_x,
   output logic [6:0]         vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic               overrun,
   output logic               timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N_REQ-1:0]   mask_q, mask_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [N_REQ-1:0]   start_q, start_d, commit_q, commit_d;
   logic               phase_q, phase_d, busy_q, busy_d, overrun_q, overrun_d;
   logic               timeout_err_q, timeout_err_d, vga_plot_q, vga_plot_d;
   logic [7:0]         vga_x_q, vga_x_d;
   logic [6:0]         vga_y_q, vga_y_d;
   logic [2:0]         vga_colour_q, vga_colour_d;

   logic               sel_valid, sel_last, turn_end, first_found, nxt_found;
   logic [7:0]         sel_x;
   logic [6:0]         sel_y;
   logic [2:0]         sel_colour;
   logic [IDX_W-1:0]   first_idx, nxt_idx;
   logic [N_REQ-1:0]   first_mask;

   // In IDLE the first index comes from the live mask, later from the snapshot.
   assign first_mask = (state_q == S_IDLE) ? active : mask_q;

   next_active_idx #(.N_REQ(N_REQ)) u_first (
      .mask(first_mask), .idx(idx_q), .wrap(1'b1), .next_idx(first_idx), .found(first_found)
   );

   next_active_idx #(.N_REQ(N_REQ)) u_next (
      .mask(mask_q), .idx(idx_q), .wrap(1'b0), .next_idx(nxt_idx), .found(nxt_found)
   );

   // Only the granted sprite's slice of the pixel buses is visible.
   always_comb begin
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_valid  = pix_valid[i];
            sel_last   = pix_last[i];
            sel_x      = pix_x[8*i +: 8];
            sel_y      = pix_y[7*i +: 7];
            sel_colour = pix_colour[3*i +: 3];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mask_d        = mask_q;
      wd_d          = wd_q;
      vga_x_d       = vga_x_q;
      vga_y_d       = vga_y_q;
      vga_colour_d  = vga_colour_q;
      vga_plot_d    = 1'b0;
      timeout_err_d = timeout_err_q;
      turn_end      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (frame_tick && first_found) begin
               mask_d  = active;
               idx_d   = first_idx;
               state_d = S_E_START;
            end
         end
         S_E_START: begin
            wd_d    = '0;
            state_d = S_E_STREAM;
         end
         S_D_START: begin
            wd_d    = '0;
            state_d = S_D_STREAM;
         end
         S_E_STREAM, S_D_STREAM: begin
            if (sel_valid) begin
               wd_d     = '0;
               turn_end = sel_last;
               // Off-screen pixels are swallowed but still end the turn on last.
               if (on_screen(sel_x, sel_y)) begin
                  vga_plot_d   = 1'b1;
                  vga_x_d      = sel_x;
                  vga_y_d      = sel_y;
                  vga_colour_d = (state_q == S_E_STREAM) ? BG_COLOUR : sel_colour;
               end
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               turn_end      = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end

            if (turn_end) begin
               if (nxt_found) begin
                  idx_d   = nxt_idx;
                  state_d = (state_q == S_E_STREAM) ? S_E_START : S_D_START;
               end else if (state_q == S_E_STREAM) begin
                  idx_d   = first_idx;
                  state_d = S_D_START;
               end else begin
                  state_d = S_COMMIT;
               end
            end
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Status outputs are registered from the next state so they line up with it.
      overrun_d = frame_tick && (state_q != S_IDLE);
      busy_d    = (state_d != S_IDLE);
      phase_d   = (state_d inside {S_D_START, S_D_STREAM, S_COMMIT}) ? PHASE_DRAW : PHASE_ERASE;
      commit_d  = (state_d == S_COMMIT) ? mask_d : '0;
      start_d   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         start_d[i] = (state_d inside {S_E_START, S_D_START}) && (idx_d == IDX_W'(i));
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         mask_q        <= '0;
         wd_q          <= '0;
         start_q       <= '0;
         commit_q      <= '0;
         phase_q       <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         vga_plot_q    <= 1'b0;
         vga_x_q       <= '0;
         vga_y_q       <= '0;
         vga_colour_q  <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         wd_q          <= wd_d;
         start_q       <= start_d;
         commit_q      <= commit_d;
         phase_q       <= phase_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         vga_plot_q    <= vga_plot_d;
         vga_x_q       <= vga_x_d;
         vga_y_q       <= vga_y_d;
         vga_colour_q  <= vga_colour_d;
      end
   end

   assign start       = start_q;
   assign commit      = commit_q;
   assign phase       = phase_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;
   assign vga_plot    = vga_plot_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// tb/tb_sprite_plot_scheduler.sv - directed self-checking bench for sprite_plot_scheduler
module tb_sprite_plot_scheduler;

   logic        CLOCK_50, resetn, frame_tick;
   logic [3:0]  active, start, commit, pix_valid, pix_last;
   logic        phase, vga_plot, busy, overrun, timeout_err;
   logic [31:0] pix_x;
   logic [27:0] pix_y;
   logic [11:0] pix_colour;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;

   sprite_plot_scheduler dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .frame_tick(frame_tick), .active(active),
      .start(start), .phase(phase), .commit(commit), .pix_valid(pix_valid),
      .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state
   int         ncyc = 0;
   int         plot_cnt, bg_cnt, commit_cnt, overrun_cnt, log_n, present_n, first_plot_n;
   logic [3:0] last_commit;
   logic [3:0] start_log [16];
   logic [7:0] last_x, first_x;
   logic [6:0] last_y, first_y;
   logic [2:0] last_c, first_c;

   // Sprite model state
   int   npix [4];
   int   cur = 0, sent = 0;
   logic armed = 0, streaming = 0, noise = 0, clip_mode = 0;
   logic [7:0] px;
   logic [6:0] py;
   logic [2:0] pc;

   always @(negedge CLOCK_50) begin
      ncyc++;
      if (vga_plot) begin
         if (plot_cnt == 0) begin
            first_plot_n = ncyc;
            first_x = vga_x; first_y = vga_y; first_c = vga_colour;
         end
         if (plot_cnt < 6 && vga_colour == 3'd0) bg_cnt++;
         plot_cnt++;
         last_x = vga_x; last_y = vga_y; last_c = vga_colour;
      end
      if (commit != 4'd0) begin commit_cnt++; last_commit = commit; end
      if (overrun) overrun_cnt++;
      if (start != 4'd0 && log_n < 16) begin
         for (int i = 0; i < 4; i++) if (start[i]) start_log[log_n] = {phase, 3'(i)};
         log_n++;
      end

      pix_valid  = 4'd0;
      pix_last   = 4'd0;
      pix_x      = {4{8'd5}};
      pix_y      = {4{7'd5}};
      pix_colour = {4{3'd1}};
      if (!resetn) begin
         armed = 0; streaming = 0;
      end else begin
         if (armed) begin
            armed = 0; sent = 0; streaming = (npix[cur] > 0);
         end
         if (streaming) begin
            if (clip_mode && cur == 1) begin
               case (sent)
                  0:       begin px = 8'd200; py = 7'd10;  end
                  1:       begin px = 8'hFF;  py = 7'h7F;  end
                  default: begin px = 8'd159; py = 7'd119; end
               endcase
               if (sent == 2 && present_n < 0) present_n = ncyc;
            end else begin
               px = 8'(40 + 10*cur + sent);
               py = 7'(50 + sent);
            end
            pc = 3'(cur + sent + 1);
            pix_x[8*cur +: 8]      = px;
            pix_y[7*cur +: 7]      = py;
            pix_colour[3*cur +: 3] = pc;
            pix_valid[cur] = 1'b1;
            pix_last[cur]  = (sent == npix[cur] - 1);
            sent++;
            if (sent >= npix[cur]) streaming = 0;
         end else if (noise && cur == 0) begin
            pix_valid = 4'b1110;
            pix_last  = 4'b1110;
         end
         if (start != 4'd0) begin
            for (int i = 0; i < 4; i++) if (start[i]) cur = i;
            armed = 1;
         end
      end
   end

   task automatic step;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic clear_mon;
      plot_cnt = 0; bg_cnt = 0; commit_cnt = 0; overrun_cnt = 0; log_n = 0;
      present_n = -1; first_plot_n = -1; last_commit = 4'd0;
   endtask

   task automatic pulse_tick(input logic [3:0] act);
      active = act;
      frame_tick = 1'b1;
      step;
      frame_tick = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin step; n++; end
      if (n >= bound) check("wait_idle_bound", 32'(busy), 32'd0);
      step; step;
   endtask

   task automatic wait_start(input logic want_phase, input int bound);
      int n = 0;
      while (!(start != 4'd0 && phase == want_phase) && n < bound) begin step; n++; end
      if (n >= bound) check("wait_start_bound", 32'(start), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; frame_tick = 1'b0; active = 4'd0;
      npix = '{0, 0, 0, 0};
      clear_mon;
      repeat (3) step;
      check("reset_outputs", {1'b0, start, phase, commit, vga_x, vga_y, vga_colour, vga_plot,
                              busy, overrun, timeout_err}, 32'd0);
      resetn = 1'b1;
      step;

      // 1: two sprites, erase then draw
      clear_mon;
      npix = '{3, 0, 3, 0};
      pulse_tick(4'b0101);
      check("t1_busy_after_tick", 32'(busy), 32'd1);
      wait_idle(400);
      check("t1_start_count", 32'(log_n), 32'd4);
      check("t1_start0", 32'(start_log[0]), 32'h0);
      check("t1_start1", 32'(start_log[1]), 32'h2);
      check("t1_start2", 32'(start_log[2]), 32'h8);
      check("t1_start3", 32'(start_log[3]), 32'hA);
      check("t1_plots", 32'(plot_cnt), 32'd12);
      check("t1_erase_bg", 32'(bg_cnt), 32'd6);
      check("t1_commit_count", 32'(commit_cnt), 32'd1);
      check("t1_commit_mask", 32'(last_commit), 32'h5);
      check("t1_last_pixel", {9'd0, last_x, last_y, last_c}, {9'd0, 8'd62, 7'd52, 3'd5});
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_no_overrun", 32'(overrun_cnt), 32'd0);

      // 2: clipping
      clear_mon;
      clip_mode = 1'b1;
      npix = '{0, 3, 0, 0};
      pulse_tick(4'b0010);
      wait_idle(400);
      clip_mode = 1'b0;
      check("t2_plots", 32'(plot_cnt), 32'd2);
      check("t2_first_xy", {17'd0, first_x, first_y}, {17'd0, 8'd159, 7'd119});
      check("t2_first_colour", 32'(first_c), 32'd0);
      check("t2_latency", 32'(first_plot_n - present_n), 32'd1);
      check("t2_commit_mask", 32'(last_commit), 32'h2);

      // 3: empty mask
      clear_mon;
      pulse_tick(4'b0000);
      repeat (10) step;
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_activity", 32'(plot_cnt + log_n + commit_cnt), 32'd0);

      // 4: overrun during draw
      clear_mon;
      npix = '{3, 0, 3, 0};
      pulse_tick(4'b0101);
      wait_start(1'b1, 400);
      step;
      frame_tick = 1'b1;
      step;
      frame_tick = 1'b0;
      wait_idle(400);
      check("t4_overrun", 32'(overrun_cnt), 32'd1);
      check("t4_commit_count", 32'(commit_cnt), 32'd1);
      check("t4_commit_mask", 32'(last_commit), 32'h5);
      check("t4_plots", 32'(plot_cnt), 32'd12);

      // 5: silent sprite times out, noise on ungranted sprites ignored
      clear_mon;
      npix = '{0, 1, 0, 0};
      noise = 1'b1;
      pulse_tick(4'b0011);
      wait_start(1'b0, 50);
      check("t5_first_start", 32'(start), 32'h1);
      repeat (64) step;
      check("t5_before_timeout", {30'd0, timeout_err, |start}, 32'd0);
      step;
      check("t5_timeout_err", 32'(timeout_err), 32'd1);
      check("t5_next_start", 32'(start), 32'h2);
      wait_idle(600);
      noise = 1'b0;
      check("t5_plots", 32'(plot_cnt), 32'd2);
      check("t5_commit_mask", 32'(last_commit), 32'h3);
      check("t5_commit_count", 32'(commit_cnt), 32'd1);
      check("t5_sticky", 32'(timeout_err), 32'd1);

      // 6: reset mid erase stream
      clear_mon;
      npix = '{3, 0, 3, 0};
      pulse_tick(4'b0101);
      step; step;
      resetn = 1'b0;
      #1;
      check("t6_async_outputs", {1'b0, start, phase, commit, vga_x, vga_y, vga_colour, vga_plot,
                                 busy, overrun, timeout_err}, 32'd0);
      step; step;
      resetn = 1'b1;
      step;
      check("t6_no_commit", 32'(commit_cnt), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      clear_mon;
      pulse_tick(4'b0101);
      check("t6_fresh_start", 32'(start), 32'h1);
      check("t6_fresh_phase", 32'(phase), 32'd0);
      wait_idle(400);
      check("t6_commit_mask", 32'(last_commit), 32'h5);
      check("t6_plots", 32'(plot_cnt), 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
